trdb_step_sequencer: RTL and testbench
======================================

# trdb_step_sequencer

Front-end controller that feeds the instruction-type detector. It buffers retired instructions from the core in a small FIFO and maintains the two-slot window the detector compares: tc (current) and nc (next). It advances the window one instruction per handshake with the packet emitter, and sequences trace start and stop so that the first and last steps of a trace session are flagged.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: input FIFO entries; power of two, ≥2.

Ports (XLEN comes from `trdb_pkg`):
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `inst_valid_i` in 1: retired instruction valid.
- `inst_ready_o` out 1: instruction accepted when asserted together with `inst_valid_i`.
- `inst_data_i` in XLEN: instruction word.
- `iaddr_i` in XLEN: instruction address.
- `compressed_i` in 1: instruction is 16-bit.
- `exception_i` in 1: instruction trapped.
- `trace_enable_i` in 1: level; tracing on.
- `pkt_ready_i` in 1: emitter consumes the current step.
- `step_valid_o` out 1: the current tc/nc window is presented for consumption.
- `tc_ready_o`, `nc_ready_o` out 1: slot-valid flags for tc and nc.
- `tc_iaddr_o` out XLEN, `tc_compressed_o` out 1, `tc_exception_o` out 1: tc slot contents.
- `nc_iaddr_o` out XLEN, `nc_inst_data_o` out XLEN, `nc_exception_o` out 1: nc slot contents.
- `first_o` out 1: the presented step is the first of the session.
- `last_o` out 1: the presented step is the final one; nc is empty.
- `busy_o` out 1: state ≠ IDLE or FIFO not empty.

## Operation
FIFO:
- `inst_ready_o = trace_enable_i && !full`.
- A write happens on `inst_valid_i && inst_ready_o`.
- There is no fall-through. The full flag uses the current count, so a write is refused while full even if a pop occurs in the same cycle.
- Entry contents: {data, iaddr, compressed, exception}.

Slot registers hold tc and nc. Each slot has a valid bit, which drives `tc_ready_o` and `nc_ready_o`.

FSM states and transitions:
- **IDLE** (tc=nc=invalid).
  - `trace_enable_i` and FIFO non-empty → pop into nc, go to LOAD1.
- **LOAD1** (nc valid only; this is an internal shift, nothing is presented).
  - FIFO non-empty → nc→tc, pop into nc, set first flag, go to RUN.
  - Else if `!trace_enable_i` → nc→tc, nc invalid, set first flag, go to DRAIN.
- **RUN** (both slots valid). `step_valid_o=1`. On handshake (`step_valid_o && pkt_ready_i`):
  - nc→tc and clear first.
  - FIFO non-empty → pop into nc, stay in RUN.
  - FIFO empty → nc invalid, go to WAIT.
- **WAIT** (tc valid only). `step_valid_o=0`.
  - FIFO non-empty → pop into nc, go to RUN.
  - Else if `!trace_enable_i` → go to DRAIN.
- **DRAIN** (tc valid only). `step_valid_o=1`, `last_o=1`.
  - On handshake → clear both slots and first, go to IDLE.

Rules:
- When `trace_enable_i` deasserts, new input stops immediately. Everything already in the FIFO is still stepped out before DRAIN.
- Re-enabling during WAIT only resumes RUN; it does not start a new session. Re-enabling during DRAIN does not abort the drain; the new session begins after IDLE.
- `first_o` = first flag && `step_valid_o`.
- `first_o` and `last_o` can be high together when a session holds a single instruction.
- While `step_valid_o && !pkt_ready_i`, all slot outputs are held stable.
- Slot data registers are not cleared when the slot valid bit drops; consumers must qualify with the ready flags.

## Timing
- Reset: all outputs 0, FIFO empty, state IDLE. Reset asserted mid-operation takes effect immediately (asynchronous) and drops buffered instructions.
- Outputs are registered, except:
  - `inst_ready_o`, which depends combinationally on `trace_enable_i`;
  - `step_valid_o`, `first_o` and `last_o`, which are decoded from state.
- Latency: an instruction accepted at the end of cycle t is in the FIFO at t+1 and in nc at t+2.
- Back-to-back start: with the first accepted at t, the second at t+1, and `pkt_ready_i=1`, the first `step_valid_o` is at t+3.
- Sustained throughput is one step per cycle.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.

## Structure
- `trdb_pkg`: XLEN, `trdb_seq_state_e` enum (IDLE, LOAD1, RUN, WAIT, DRAIN), and the FIFO entry struct `trdb_inst_entry_t`.
- One sub-module, `trdb_inst_fifo`: a synchronous FIFO with push/pop/full/empty, parameterised on depth and entry type.
- The top level contains the FSM and the slot registers. Its tc/nc outputs connect directly to the itype detector.

## Test plan
- **Reset:** assert `rst_ni=0` mid-RUN → all outputs 0 asynchronously; after release `busy_o=0` and state is IDLE.
- **Back-to-back start:** enable, push 0x100/0x104/0x108 (uncompressed) at t, t+1, t+2 with `pkt_ready_i=1` →
  - t+3: `step_valid_o=1`, tc=0x100, nc=0x104, `first_o=1`;
  - t+4: tc=0x104, nc=0x108, `first_o=0`;
  - t+5: WAIT with `nc_ready_o=0`.
- **Backpressure:** `FIFO_DEPTH=4`, `pkt_ready_i=0`, push 8 instructions → `inst_ready_o` falls once the FIFO holds 4 with both slots full. Outputs stay stable. Releasing `pkt_ready_i` steps each instruction exactly once, in order.
- **Single-instruction session:** push 0x200, then deassert enable → one step with tc=0x200, `nc_ready_o=0`, `first_o=last_o=1`; IDLE after the handshake.
- **Disable with pending data:** deassert enable with 3 entries pending → `inst_ready_o=0` at once; the 3 pending entries are stepped out in order; the final step has `last_o=1`; then `busy_o=0`.
- **Exception propagation:** push an entry with `exception_i=1` at 0x300 → `nc_exception_o=1` while nc=0x300, then `tc_exception_o=1` on the following step.

Source files
------------

// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared types for the trace front-end step sequencer
package trdb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD1,
    RUN,
    WAIT,
    DRAIN
  } trdb_seq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] iaddr;
    logic            compressed;
    logic            exception;
  } trdb_inst_entry_t;

endpackage

// File: rtl/trdb_inst_fifo.sv
// rtl/trdb_inst_fifo.sv - synchronous FIFO for retired instructions, no fall-through
module trdb_inst_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Full is taken from the current count, so a pop in the same cycle never frees a slot early.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/trdb_step_sequencer.sv
// rtl/trdb_step_sequencer.sv - buffers retired instructions and steps the tc/nc window
// for the itype detector, flagging the first and last step of each trace session.
module trdb_step_sequencer
  import trdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [XLEN-1:0] inst_data_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic            compressed_i,
  input  logic            exception_i,
  input  logic            trace_enable_i,
  input  logic            pkt_ready_i,
  output logic            step_valid_o,
  output logic            tc_ready_o,
  output logic            nc_ready_o,
  output logic [XLEN-1:0] tc_iaddr_o,
  output logic            tc_compressed_o,
  output logic            tc_exception_o,
  output logic [XLEN-1:0] nc_iaddr_o,
  output logic [XLEN-1:0] nc_inst_data_o,
  output logic            nc_exception_o,
  output logic            first_o,
  output logic            last_o,
  output logic            busy_o
);

  trdb_seq_state_e  state;
  trdb_inst_entry_t fifo_wdata;
  trdb_inst_entry_t fifo_rdata;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             shift;
  logic             first;
  logic             nc_compressed;

  assign inst_ready_o = trace_enable_i && !fifo_full;
  assign fifo_push    = inst_valid_i && inst_ready_o;
  assign fifo_wdata   = {inst_data_i, iaddr_i, compressed_i, exception_i};

  assign step_valid_o = (state == RUN) || (state == DRAIN);
  assign last_o       = (state == DRAIN);
  assign first_o      = first && step_valid_o;
  assign busy_o       = (state != IDLE) || !fifo_empty;

  trdb_inst_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (trdb_inst_entry_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // shift moves nc into tc; pop refills nc from the FIFO head.
  always_comb begin
    fifo_pop = 1'b0;
    shift    = 1'b0;
    case (state)
      IDLE:  fifo_pop = trace_enable_i && !fifo_empty;
      LOAD1: begin
        fifo_pop = !fifo_empty;
        shift    = !fifo_empty || !trace_enable_i;
      end
      RUN: begin
        fifo_pop = pkt_ready_i && !fifo_empty;
        shift    = pkt_ready_i;
      end
      WAIT:    fifo_pop = !fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      first           <= 1'b0;
      tc_ready_o      <= 1'b0;
      nc_ready_o      <= 1'b0;
      tc_iaddr_o      <= '0;
      tc_compressed_o <= 1'b0;
      tc_exception_o  <= 1'b0;
      nc_iaddr_o      <= '0;
      nc_inst_data_o  <= '0;
      nc_exception_o  <= 1'b0;
      nc_compressed   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            state <= LOAD1;
          end
        end
        LOAD1: begin
          if (shift) begin
            first <= 1'b1;
            state <= fifo_pop ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (shift) begin
            first <= 1'b0;
            if (!fifo_pop) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (fifo_pop) begin
            state <= RUN;
          end else if (!trace_enable_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pkt_ready_i) begin
            tc_ready_o <= 1'b0;
            first      <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (shift) begin
        tc_ready_o      <= 1'b1;
        tc_iaddr_o      <= nc_iaddr_o;
        tc_compressed_o <= nc_compressed;
        tc_exception_o  <= nc_exception_o;
      end

      // Slot payloads are left as-is when a valid bit drops.
      if (fifo_pop) begin
        nc_ready_o     <= 1'b1;
        nc_iaddr_o     <= fifo_rdata.iaddr;
        nc_inst_data_o <= fifo_rdata.data;
        nc_exception_o <= fifo_rdata.exception;
        nc_compressed  <= fifo_rdata.compressed;
      end else if (shift) begin
        nc_ready_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trdb_step_sequencer.sv
// tb/tb_trdb_step_sequencer.sv - scoreboard bench for trdb_step_sequencer
module tb_trdb_step_sequencer;
  import trdb_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            inst_valid_i;
  logic            inst_ready_o;
  logic [XLEN-1:0] inst_data_i;
  logic [XLEN-1:0] iaddr_i;
  logic            compressed_i;
  logic            exception_i;
  logic            trace_enable_i;
  logic            pkt_ready_i;
  logic            step_valid_o;
  logic            tc_ready_o;
  logic            nc_ready_o;
  logic [XLEN-1:0] tc_iaddr_o;
  logic            tc_compressed_o;
  logic            tc_exception_o;
  logic [XLEN-1:0] nc_iaddr_o;
  logic [XLEN-1:0] nc_inst_data_o;
  logic            nc_exception_o;
  logic            first_o;
  logic            last_o;
  logic            busy_o;

  trdb_step_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .inst_valid_i    (inst_valid_i),
    .inst_ready_o    (inst_ready_o),
    .inst_data_i     (inst_data_i),
    .iaddr_i         (iaddr_i),
    .compressed_i    (compressed_i),
    .exception_i     (exception_i),
    .trace_enable_i  (trace_enable_i),
    .pkt_ready_i     (pkt_ready_i),
    .step_valid_o    (step_valid_o),
    .tc_ready_o      (tc_ready_o),
    .nc_ready_o      (nc_ready_o),
    .tc_iaddr_o      (tc_iaddr_o),
    .tc_compressed_o (tc_compressed_o),
    .tc_exception_o  (tc_exception_o),
    .nc_iaddr_o      (nc_iaddr_o),
    .nc_inst_data_o  (nc_inst_data_o),
    .nc_exception_o  (nc_exception_o),
    .first_o         (first_o),
    .last_o          (last_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] tc;
    logic            tc_c;
    logic            tc_e;
    logic            nc_v;
    logic [XLEN-1:0] nc;
    logic            nc_e;
    logic            first;
    logic            last;
  } step_t;

  step_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [XLEN-1:0] data_of(input logic [XLEN-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_step(input logic [XLEN-1:0] tc, input logic tc_c, input logic tc_e,
                             input logic nc_v, input logic [XLEN-1:0] nc, input logic nc_e,
                             input logic first, input logic last);
    step_t s;
    s.tc = tc; s.tc_c = tc_c; s.tc_e = tc_e; s.nc_v = nc_v;
    s.nc = nc; s.nc_e = nc_e; s.first = first; s.last = last;
    exp_q.push_back(s);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_inst(input logic [XLEN-1:0] a, input logic c, input logic e);
    int t;
    t = 0;
    inst_valid_i = 1'b1;
    iaddr_i      = a;
    inst_data_i  = data_of(a);
    compressed_i = c;
    exception_i  = e;
    @(negedge clk_i);
    while (!inst_ready_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got inst_ready_o=0, required 1 for 0x%0h", a);
    end
    @(posedge clk_i);
    #1;
    inst_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk_i);
    while (busy_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    check(name, 64'(busy_o), 64'(0));
    check({name, "_slots"}, 64'({tc_ready_o, nc_ready_o, step_valid_o}), 64'(0));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    cyc();
  endtask

  // Scoreboard monitor: every handshake consumes one expected step.
  always @(negedge clk_i) begin : monitor
    step_t s;
    if (rst_ni && step_valid_o && pkt_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_step: got step tc=0x%0h, required no step", tc_iaddr_o);
      end else begin
        s = exp_q.pop_front();
        check("step_tc_iaddr", 64'(tc_iaddr_o), 64'(s.tc));
        check("step_flags {tc_ready,c,e,first,last,nc_ready}",
              64'({tc_ready_o, tc_compressed_o, tc_exception_o, first_o, last_o, nc_ready_o}),
              64'({1'b1, s.tc_c, s.tc_e, s.first, s.last, s.nc_v}));
        if (s.nc_v) begin
          check("step_nc_iaddr", 64'(nc_iaddr_o), 64'(s.nc));
          check("step_nc_data", 64'(nc_inst_data_o), 64'(data_of(s.nc)));
          check("step_nc_exception", 64'(nc_exception_o), 64'(s.nc_e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; inst_valid_i = 1'b0; inst_data_i = '0; iaddr_i = '0;
    compressed_i = 1'b0; exception_i = 1'b0; trace_enable_i = 1'b0; pkt_ready_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("reset_outputs", 64'({step_valid_o, tc_ready_o, nc_ready_o, first_o, last_o, busy_o, inst_ready_o}), 64'(0));
    check("reset_tc_iaddr", 64'(tc_iaddr_o), 64'(0));
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Back-to-back start
    trace_enable_i = 1'b1;
    pkt_ready_i    = 1'b1;
    #1;
    check("enable_ready", 64'(inst_ready_o), 64'(1));
    expect_step(32'h100, 1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0);
    expect_step(32'h104, 1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
    expect_step(32'h108, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
    push_inst(32'h100, 1'b0, 1'b0);
    push_inst(32'h104, 1'b0, 1'b0);
    push_inst(32'h108, 1'b0, 1'b0);
    @(negedge clk_i);
    check("b2b_t3_flags", 64'({step_valid_o, first_o, nc_ready_o}), 64'(3'b111));
    check("b2b_t3_tc", 64'(tc_iaddr_o), 64'(32'h100));
    check("b2b_t3_nc", 64'(nc_iaddr_o), 64'(32'h104));
    cyc();
    @(negedge clk_i);
    check("b2b_t4_flags", 64'({step_valid_o, first_o}), 64'(2'b10));
    check("b2b_t4_tc", 64'(tc_iaddr_o), 64'(32'h104));
    check("b2b_t4_nc", 64'(nc_iaddr_o), 64'(32'h108));
    cyc();
    @(negedge clk_i);
    check("b2b_t5_wait", 64'({step_valid_o, tc_ready_o, nc_ready_o}), 64'(3'b010));
    cyc();
    trace_enable_i = 1'b0;
    wait_idle("b2b_idle");

    // Backpressure with FIFO_DEPTH=4
    trace_enable_i = 1'b1;
    pkt_ready_i    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_step(32'h1000 + 32'(4*i), 1'b0, 1'b0, (i < 7), 32'h1000 + 32'(4*(i+1)), 1'b0,
                  (i == 0), (i == 7));
    end
    for (int i = 0; i < 6; i++) begin
      push_inst(32'h1000 + 32'(4*i), 1'b0, 1'b0);
    end
    inst_valid_i = 1'b1;
    iaddr_i      = 32'h1018;
    inst_data_i  = data_of(32'h1018);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_ready_low", 64'(inst_ready_o), 64'(0));
      check("bp_hold_flags", 64'({step_valid_o, first_o, tc_ready_o, nc_ready_o}), 64'(4'b1111));
      check("bp_hold_tc", 64'(tc_iaddr_o), 64'(32'h1000));
      check("bp_hold_nc", 64'(nc_iaddr_o), 64'(32'h1004));
    end
    cyc();
    pkt_ready_i = 1'b1;
    push_inst(32'h1018, 1'b0, 1'b0);
    push_inst(32'h101C, 1'b0, 1'b0);
    cyc();
    trace_enable_i = 1'b0;
    wait_idle("bp_idle");

    // Single-instruction session
    trace_enable_i = 1'b1;
    pkt_ready_i    = 1'b1;
    expect_step(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    push_inst(32'h200, 1'b1, 1'b0);
    cyc();
    trace_enable_i = 1'b0;
    wait_idle("single_idle");

    // Disable with pending data
    trace_enable_i = 1'b1;
    pkt_ready_i    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_step(32'h3000 + 32'(4*i), 1'b0, 1'b0, (i < 4), 32'h3000 + 32'(4*(i+1)), 1'b0,
                  (i == 0), (i == 4));
    end
    for (int i = 0; i < 5; i++) begin
      push_inst(32'h3000 + 32'(4*i), 1'b0, 1'b0);
    end
    trace_enable_i = 1'b0;
    #1;
    check("disable_ready_low", 64'(inst_ready_o), 64'(0));
    check("disable_busy", 64'(busy_o), 64'(1));
    cyc();
    pkt_ready_i = 1'b1;
    wait_idle("disable_idle");

    // Exception propagation
    trace_enable_i = 1'b1;
    pkt_ready_i    = 1'b0;
    expect_step(32'h2FC, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    expect_step(32'h300, 1'b0, 1'b1, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    expect_step(32'h304, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
    push_inst(32'h2FC, 1'b0, 1'b0);
    push_inst(32'h300, 1'b0, 1'b1);
    push_inst(32'h304, 1'b0, 1'b0);
    @(negedge clk_i);
    check("exc_nc_addr", 64'(nc_iaddr_o), 64'(32'h300));
    check("exc_nc_tc", 64'({nc_exception_o, tc_exception_o}), 64'(2'b10));
    cyc();
    pkt_ready_i = 1'b1;
    cyc();
    @(negedge clk_i);
    check("exc_tc_addr", 64'(tc_iaddr_o), 64'(32'h300));
    check("exc_tc_flag", 64'(tc_exception_o), 64'(1));
    cyc();
    trace_enable_i = 1'b0;
    wait_idle("exc_idle");

    // Asynchronous reset mid-RUN drops buffered instructions
    trace_enable_i = 1'b1;
    pkt_ready_i    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_inst(32'h500 + 32'(4*i), 1'b0, 1'b1);
    end
    @(negedge clk_i);
    check("pre_reset_run", 64'({step_valid_o, busy_o}), 64'(2'b11));
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_flags", 64'({step_valid_o, tc_ready_o, nc_ready_o, first_o, last_o, busy_o}), 64'(0));
    check("async_reset_tc", 64'({tc_iaddr_o, tc_compressed_o, tc_exception_o}), 64'(0));
    check("async_reset_nc", 64'({nc_iaddr_o, nc_exception_o}), 64'(0));
    check("async_reset_nc_data", 64'(nc_inst_data_o), 64'(0));
    trace_enable_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();
    check("post_reset_busy", 64'(busy_o), 64'(0));
    trace_enable_i = 1'b1;
    pkt_ready_i    = 1'b1;
    expect_step(32'h600, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    push_inst(32'h600, 1'b0, 1'b0);
    cyc();
    trace_enable_i = 1'b0;
    wait_idle("post_reset_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
